// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles the signals between the instruction fetch unit, the PC unit, the
// instruction memory and the decode stage.
//
//   PC        32  PC unit -> fetch    current fetch address, bit31 = supervisor
//   pc_en      1  fetch -> PC unit    advance PC on this edge (combinational)
//   flush      1  PC unit -> fetch    redirect target loaded into PC this edge
//   mem_req    1  fetch -> memory     read request
//   mem_addr  32  fetch -> memory     registered word address
//   mem_ack    1  memory -> fetch     one-cycle completion strobe
//   mem_rdata 32  memory -> fetch     read data, valid with mem_ack
//   ir_valid   1  fetch -> decode     IR/IR_PC hold an instruction
//   IR        32  fetch -> decode     fetched instruction
//   IR_PC     32  fetch -> decode     PC the instruction was fetched from
//   ir_ready   1  decode -> fetch     decode accepts IR
//   fetch_err  1  fetch -> system     sticky watchdog error
//
// Modport master is the fetch unit; modport slave is its environment.
// ---------------------------------------------------------------------------
interface instr_fetch_if;
    logic [31:0] PC;
    logic        pc_en;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic [31:0] IR;
    logic [31:0] IR_PC;
    logic        ir_ready;
    logic        fetch_err;

    modport master (
        input  PC, flush, mem_ack, mem_rdata, ir_ready,
        output pc_en, mem_req, mem_addr, ir_valid, IR, IR_PC, fetch_err
    );

    modport slave (
        output PC, flush, mem_ack, mem_rdata, ir_ready,
        input  pc_en, mem_req, mem_addr, ir_valid, IR, IR_PC, fetch_err
    );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Single-outstanding-request instruction fetch unit. Issues a word read for
// the current PC, latches the returned instruction into IR/IR_PC and holds it
// until decode accepts it or a flush discards it. A watchdog counts unacked
// request cycles and parks the unit in a sticky error state after WDOG_MAX.
//
// Parameters
//   WDOG_MAX  consecutive unacked request cycles before fetch_err (1..255)
//
// Ports
//   clk    rising-edge clock
//   RESET  synchronous, active-high reset
//   bus    instr_fetch_if.master (PC unit, memory and decode signals)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic          clk,
    input  logic          RESET,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL,
        S_ERR
    } state_t;

    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_MAX);

    state_t      state;
    logic        drop;      // outstanding request belongs to a flushed path
    logic [7:0]  wdog;      // unacked request cycles in this transaction
    logic [31:0] fetch_pc;  // PC that produced the outstanding request

    // Instruction accepted this cycle: the only case that advances PC.
    always_comb begin
        bus.pc_en = 1'b0;
        if (!RESET && state == S_REQ && bus.mem_ack && !drop && !bus.flush)
            bus.pc_en = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state         <= S_IDLE;
            drop          <= 1'b0;
            wdog          <= '0;
            fetch_pc      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.ir_valid  <= 1'b0;
            bus.IR        <= '0;
            bus.IR_PC     <= '0;
            bus.fetch_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state        <= S_REQ;
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= {1'b0, bus.PC[30:2], 2'b00};
                    fetch_pc     <= bus.PC;
                    wdog         <= '0;
                end

                S_REQ: begin
                    if (bus.mem_ack) begin
                        if (drop || bus.flush) begin
                            // Stale data: discard and re-issue from the
                            // current PC without leaving REQ.
                            drop         <= 1'b0;
                            bus.mem_addr <= {1'b0, bus.PC[30:2], 2'b00};
                            fetch_pc     <= bus.PC;
                            wdog         <= '0;
                        end else begin
                            bus.IR       <= bus.mem_rdata;
                            bus.IR_PC    <= fetch_pc;
                            bus.ir_valid <= 1'b1;
                            bus.mem_req  <= 1'b0;
                            state        <= S_FULL;
                        end
                    end else begin
                        // A flush cannot abort the bus cycle; remember to
                        // throw its data away when it finally completes.
                        if (bus.flush)
                            drop <= 1'b1;
                        wdog <= wdog + 8'd1;
                        if ((wdog + 8'd1) == WDOG_LIMIT) begin
                            state         <= S_ERR;
                            bus.mem_req   <= 1'b0;
                            bus.fetch_err <= 1'b1;
                        end
                    end
                end

                S_FULL: begin
                    // flush wins over ir_ready: both leave IR dropped here,
                    // the difference is only whether decode consumed it.
                    if (bus.flush || bus.ir_ready) begin
                        bus.ir_valid <= 1'b0;
                        state        <= S_REQ;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {1'b0, bus.PC[30:2], 2'b00};
                        fetch_pc     <= bus.PC;
                        wdog         <= '0;
                    end
                end

                S_ERR: begin
                    bus.mem_req   <= 1'b0;
                    bus.ir_valid  <= 1'b0;
                    bus.fetch_err <= 1'b1;
                end

                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic clk;
    logic RESET;
    logic RESET_W;

    int tests;
    int failed;

    instr_fetch_if bus ();
    instr_fetch_if wbus ();

    instr_fetch dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus.master)
    );

    instr_fetch #(.WDOG_MAX(4)) dut_w (
        .clk   (clk),
        .RESET (RESET_W),
        .bus   (wbus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.PC = 32'h8000_0000;
        step();
        step();
        RESET = 1'b0;
        step();
        tests++;
        if (bus.mem_req !== 1'b1) begin
            failed++;
            $display("FAIL reset_release_req: got %b expected 1", bus.mem_req);
        end
        // Reset must override ack and flush while a request is outstanding.
        RESET = 1'b1;
        bus.mem_ack = 1'b1;
        bus.flush = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        tests++;
        if (bus.pc_en !== 1'b0) begin
            failed++;
            $display("FAIL reset_pc_en: got %b expected 0", bus.pc_en);
        end
        step();
        tests++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.ir_valid !== 1'b0 ||
            bus.IR !== 32'h0 || bus.IR_PC !== 32'h0 || bus.fetch_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_outputs: got req=%b addr=%h v=%b ir=%h irpc=%h err=%b expected all zero",
                     bus.mem_req, bus.mem_addr, bus.ir_valid, bus.IR, bus.IR_PC, bus.fetch_err);
        end
        bus.mem_ack = 1'b0;
        bus.flush = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic test_basic();
        bus.PC = 32'h8000_0000;
        RESET = 1'b0;
        step();
        tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0000) begin
            failed++;
            $display("FAIL basic_req: got req=%b addr=%h expected 1 00000000", bus.mem_req, bus.mem_addr);
        end
        #1;
        tests++;
        if (bus.pc_en !== 1'b0) begin
            failed++;
            $display("FAIL basic_no_ack_pc_en: got %b expected 0", bus.pc_en);
        end
        step();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        #1;
        tests++;
        if (bus.pc_en !== 1'b1) begin
            failed++;
            $display("FAIL basic_pc_en: got %b expected 1", bus.pc_en);
        end
        step();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.PC = 32'h8000_0004;
        #1;
        tests++;
        if (bus.pc_en !== 1'b0 || bus.ir_valid !== 1'b1 || bus.IR !== 32'h1234_5678 ||
            bus.IR_PC !== 32'h8000_0000 || bus.mem_req !== 1'b0) begin
            failed++;
            $display("FAIL basic_full: got pc_en=%b v=%b ir=%h irpc=%h req=%b expected 0 1 12345678 80000000 0",
                     bus.pc_en, bus.ir_valid, bus.IR, bus.IR_PC, bus.mem_req);
        end
    endtask

    task automatic test_stall();
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // A stray ack while FULL must be ignored.
            bus.mem_ack = (i == 2);
            bus.mem_rdata = 32'hDEAD_BEEF;
            #1;
            tests++;
            if (bus.pc_en !== 1'b0) begin
                failed++;
                $display("FAIL stall_pc_en[%0d]: got %b expected 0", i, bus.pc_en);
            end
            step();
            tests++;
            if (bus.ir_valid !== 1'b1 || bus.IR !== 32'h1234_5678 ||
                bus.IR_PC !== 32'h8000_0000 || bus.mem_req !== 1'b0) begin
                failed++;
                $display("FAIL stall_hold[%0d]: got v=%b ir=%h irpc=%h req=%b expected 1 12345678 80000000 0",
                         i, bus.ir_valid, bus.IR, bus.IR_PC, bus.mem_req);
            end
        end
        bus.mem_ack = 1'b0;
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
        tests++;
        if (bus.ir_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0004) begin
            failed++;
            $display("FAIL stall_release: got v=%b req=%b addr=%h expected 0 1 00000004",
                     bus.ir_valid, bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_flush_req();
        // Outstanding request at 0x4; redirect to 0x100 without an ack.
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.PC = 32'h0000_0100;
        tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0004) begin
            failed++;
            $display("FAIL flush_req_hold: got req=%b addr=%h expected 1 00000004", bus.mem_req, bus.mem_addr);
        end
        step();
        step();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        #1;
        tests++;
        if (bus.pc_en !== 1'b0) begin
            failed++;
            $display("FAIL flush_req_pc_en: got %b expected 0", bus.pc_en);
        end
        step();
        bus.mem_ack = 1'b0;
        tests++;
        if (bus.ir_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0100) begin
            failed++;
            $display("FAIL flush_req_reissue: got v=%b req=%b addr=%h expected 0 1 00000100",
                     bus.ir_valid, bus.mem_req, bus.mem_addr);
        end
        step();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hA5A5_0001;
        #1;
        tests++;
        if (bus.pc_en !== 1'b1) begin
            failed++;
            $display("FAIL flush_req_accept_pc_en: got %b expected 1", bus.pc_en);
        end
        step();
        bus.mem_ack = 1'b0;
        bus.PC = 32'h0000_0104;
        tests++;
        if (bus.ir_valid !== 1'b1 || bus.IR !== 32'hA5A5_0001 || bus.IR_PC !== 32'h0000_0100) begin
            failed++;
            $display("FAIL flush_req_ir: got v=%b ir=%h irpc=%h expected 1 a5a50001 00000100",
                     bus.ir_valid, bus.IR, bus.IR_PC);
        end
    endtask

    task automatic test_flush_ack();
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
        tests++;
        if (bus.mem_addr !== 32'h0000_0104 || bus.mem_req !== 1'b1) begin
            failed++;
            $display("FAIL flush_ack_req: got addr=%h req=%b expected 00000104 1", bus.mem_addr, bus.mem_req);
        end
        // The PC unit already presents the redirect target in the flush cycle.
        bus.PC = 32'h0000_0200;
        bus.flush = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hCAFE_0000;
        #1;
        tests++;
        if (bus.pc_en !== 1'b0) begin
            failed++;
            $display("FAIL flush_ack_pc_en: got %b expected 0", bus.pc_en);
        end
        step();
        bus.flush = 1'b0;
        bus.mem_ack = 1'b0;
        tests++;
        if (bus.ir_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0200) begin
            failed++;
            $display("FAIL flush_ack_reissue: got v=%b req=%b addr=%h expected 0 1 00000200",
                     bus.ir_valid, bus.mem_req, bus.mem_addr);
        end
        // drop must be clear: the very next ack is accepted.
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        #1;
        tests++;
        if (bus.pc_en !== 1'b1) begin
            failed++;
            $display("FAIL flush_ack_next_pc_en: got %b expected 1", bus.pc_en);
        end
        step();
        bus.mem_ack = 1'b0;
        bus.PC = 32'h0000_0204;
        tests++;
        if (bus.ir_valid !== 1'b1 || bus.IR !== 32'h0BAD_F00D || bus.IR_PC !== 32'h0000_0200) begin
            failed++;
            $display("FAIL flush_ack_ir: got v=%b ir=%h irpc=%h expected 1 0badf00d 00000200",
                     bus.ir_valid, bus.IR, bus.IR_PC);
        end
    endtask

    task automatic test_flush_full();
        bus.PC = 32'h8000_0300;
        bus.flush = 1'b1;
        bus.ir_ready = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.ir_ready = 1'b0;
        tests++;
        if (bus.ir_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0300) begin
            failed++;
            $display("FAIL flush_full: got v=%b req=%b addr=%h expected 0 1 00000300",
                     bus.ir_valid, bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h7777_0300;
        step();
        bus.mem_ack = 1'b0;
        tests++;
        if (bus.IR_PC !== 32'h8000_0300 || bus.IR !== 32'h7777_0300) begin
            failed++;
            $display("FAIL flush_full_ir: got ir=%h irpc=%h expected 77770300 80000300", bus.IR, bus.IR_PC);
        end
    endtask

    task automatic test_watchdog();
        wbus.PC = 32'h0000_0040;
        RESET_W = 1'b1;
        step();
        RESET_W = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (wbus.fetch_err !== 1'b0 || wbus.mem_req !== 1'b1) begin
                failed++;
                $display("FAIL wdog_early[%0d]: got err=%b req=%b expected 0 1", i, wbus.fetch_err, wbus.mem_req);
            end
        end
        step();
        tests++;
        if (wbus.fetch_err !== 1'b1 || wbus.mem_req !== 1'b0) begin
            failed++;
            $display("FAIL wdog_trip: got err=%b req=%b expected 1 0", wbus.fetch_err, wbus.mem_req);
        end
        wbus.mem_ack = 1'b1;
        wbus.ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (wbus.pc_en !== 1'b0) begin
                failed++;
                $display("FAIL wdog_err_pc_en[%0d]: got %b expected 0", i, wbus.pc_en);
            end
            step();
            tests++;
            if (wbus.fetch_err !== 1'b1 || wbus.mem_req !== 1'b0 || wbus.ir_valid !== 1'b0) begin
                failed++;
                $display("FAIL wdog_hold[%0d]: got err=%b req=%b v=%b expected 1 0 0",
                         i, wbus.fetch_err, wbus.mem_req, wbus.ir_valid);
            end
        end
        wbus.mem_ack = 1'b0;
        wbus.ir_ready = 1'b0;
        RESET_W = 1'b1;
        step();
        tests++;
        if (wbus.fetch_err !== 1'b0 || wbus.mem_req !== 1'b0 || wbus.mem_addr !== 32'h0 ||
            wbus.ir_valid !== 1'b0 || wbus.IR !== 32'h0 || wbus.IR_PC !== 32'h0) begin
            failed++;
            $display("FAIL wdog_reset: got err=%b req=%b addr=%h v=%b ir=%h irpc=%h expected all zero",
                     wbus.fetch_err, wbus.mem_req, wbus.mem_addr, wbus.ir_valid, wbus.IR, wbus.IR_PC);
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        RESET = 1'b1;
        RESET_W = 1'b1;
        bus.PC = 32'h8000_0000;
        bus.flush = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.ir_ready = 1'b0;
        wbus.PC = 32'h0;
        wbus.flush = 1'b0;
        wbus.mem_ack = 1'b0;
        wbus.mem_rdata = 32'h0;
        wbus.ir_ready = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_flush_req();
        test_flush_ack();
        test_flush_full();
        test_watchdog();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
